// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC generator feeding a DEPTH-entry fetch buffer with redirect flush.
// Optional macro FETCH_HALT_EN stops fetching after an ECALL/EBREAK until redirect or reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Instr_Addr,
  input  logic [31:0] Instr_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_C    = 32'h0000_0013;

`ifdef FETCH_HALT_EN
  localparam logic [31:0] ECALL_C  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_C = 32'h0010_0073;
  typedef enum logic {RUN, HALT} state_t;
`else
  typedef enum logic {RUN} state_t;
`endif

  state_t               state_q;
  logic [31:0]          pc_q;
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q, rd_next;
  logic [CNT_W-1:0]     count_q;
  logic [31:0]          buf_instr [DEPTH];
  logic [31:0]          buf_pc    [DEPTH];
  logic [31:0]          out_instr_q, out_pc_q;
  logic [31:0]          head_instr_d, head_pc_d;
  logic                 pop, push;

  assign Instr_Addr = pc_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = out_instr_q;
  assign out_pc     = out_pc_q;

  assign pop     = out_valid && out_ready;
  assign push    = (state_q == RUN) && !redirect_valid && ((count_q != FULL_C) || pop);
  assign rd_next = rd_ptr_q + PTR_W'(1);

  // Next head: the entry behind the popped one, or the word being pushed into an
  // empty (or just-emptied) buffer; otherwise the registered head simply holds.
  always_comb begin
    head_instr_d = out_instr_q;
    head_pc_d    = out_pc_q;
    if (pop && (count_q > CNT_W'(1))) begin
      head_instr_d = buf_instr[rd_next];
      head_pc_d    = buf_pc[rd_next];
    end else if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
      head_instr_d = Instr_rdata;
      head_pc_d    = pc_q;
    end
  end

  // NOTE: buffer storage has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_instr[wr_ptr_q] <= Instr_rdata;
      buf_pc[wr_ptr_q]    <= pc_q;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_instr_q <= NOP_C;
      out_pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      state_q  <= RUN;
      pc_q     <= {redirect_addr[31:2], 2'b00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_next;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        pc_q     <= pc_q + 32'd4;
`ifdef FETCH_HALT_EN
        if ((Instr_rdata == ECALL_C) || (Instr_rdata == EBREAK_C)) state_q <= HALT;
`endif
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      out_instr_q <= head_instr_d;
      out_pc_q    <= head_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic checked against a queue-based model.
// Define FETCH_HALT_EN for both bench and RTL to exercise the halt variant.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_C    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr_Addr, Instr_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] salt;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Instr_Addr(Instr_Addr), .Instr_rdata(Instr_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed words at 0/4/8, otherwise a salted hash with bit 31 set
  // so that no filler word can look like ECALL/EBREAK.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0031_00B3;
      32'h4:   return 32'h4062_8233;
      32'h8:   return 32'h0000_0073;
      default: return ((a * 32'h9E37_79B1) ^ salt) | 32'h8000_0000;
    endcase
  endfunction

  always_comb Instr_rdata = mem_word(Instr_Addr);

  // Reference model: a queue of {pc, instr} entries plus a PC and a halt flag.
  logic [63:0] m_q[$];
  logic [31:0] m_pc, m_last_pc, m_last_instr;
  logic        m_halt, m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rv, input logic [31:0] ra, input logic rdy);
    logic pop, can_push;
    logic [31:0] w;
    if (r) begin
      m_q.delete();
      m_pc = RESET_PC; m_halt = 1'b0;
      m_last_pc = RESET_PC; m_last_instr = NOP_C;
      m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    if (rv) begin
      m_q.delete();
      m_pc = {ra[31:2], 2'b00};
      m_halt = 1'b0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    can_push = !m_halt && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (can_push) begin
      w = mem_word(m_pc);
      m_q.push_back({m_pc, w});
`ifdef FETCH_HALT_EN
      if (w == 32'h0000_0073 || w == 32'h0010_0073) m_halt = 1'b1;
`endif
      m_pc = m_pc + 32'd4;
    end
    if (m_q.size() > 0) begin
      m_last_pc = m_q[0][63:32];
      m_last_instr = m_q[0][31:0];
    end
  endtask

  // One clock: compare DUT against the model, drive the next inputs, advance the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] ra, input logic rdy);
    @(negedge clk);
    if (m_known) begin
      check("out_valid",  {31'b0, out_valid}, {31'b0, m_q.size() > 0});
      check("Instr_Addr", Instr_Addr, m_pc);
      check("out_pc",     out_pc, m_last_pc);
      check("out_instr",  out_instr, m_last_instr);
    end
    reset = r; redirect_valid = rv; redirect_addr = ra; out_ready = rdy;
    model_step(r, rv, ra, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    salt = $urandom;

    // Reset state
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_addr",  Instr_Addr, RESET_PC);
    check("rst_instr", out_instr, NOP_C);
    check("rst_pc",    out_pc, RESET_PC);

    // Streaming: one instruction per cycle, first fetch in the first cycle out of reset
    cycle(0, 0, 0, 1);
    check("s0_valid", {31'b0, out_valid}, 32'h1);
    check("s0_pc",    out_pc, 32'h0);
    check("s0_instr", out_instr, 32'h0031_00B3);
    cycle(0, 0, 0, 1);
    check("s1_pc",    out_pc, 32'h4);
    check("s1_instr", out_instr, 32'h4062_8233);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Backpressure: buffer saturates, PC holds, order kept
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    check("bp_addr", Instr_Addr, 32'h8);
    check("bp_pc",   out_pc, 32'h0);
    cycle(0, 0, 0, 1);
    check("bp_pc1",  out_pc, 32'h4);

    // Redirect with a full buffer and a pop in the same cycle
    cycle(0, 1, 32'h0000_0023, 1);
    check("rd_valid", {31'b0, out_valid}, 32'h0);
    check("rd_addr",  Instr_Addr, 32'h20);
    cycle(0, 0, 0, 1);
    check("rd_pc",    out_pc, 32'h20);

    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 0, 1);
    check("wr_pc0", out_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    check("wr_pc1", out_pc, 32'h0);
    cycle(0, 0, 0, 1);
    check("wr_pc2", out_pc, 32'h4);

    // Mid-stream reset with a full buffer, then reset overriding a redirect
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("mr_valid", {31'b0, out_valid}, 32'h0);
    check("mr_addr",  Instr_Addr, RESET_PC);
    cycle(1, 1, 32'h100, 1);
    check("mr_rv_addr", Instr_Addr, RESET_PC);

    // ECALL at address 8: halts with the macro, ordinary word without it
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);
`ifdef FETCH_HALT_EN
    check("halt_addr", Instr_Addr, 32'hC);
`else
    check("nohalt_addr", Instr_Addr, 32'h18);
`endif
    cycle(0, 1, 32'h0, 1);
    cycle(0, 0, 0, 1);
    check("resume_addr", Instr_Addr, 32'h4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic r, rv, rdy;
      logic [31:0] ra;
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_00FF);
      cycle(r, rv, ra, rdy);
    end
    cycle(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of fetch-buffer entries (legal values 2, 4 or 8).
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Instr_Addr  output  32  byte address to the combinational instruction memory; always equals the PC register.
REQ-007 Instr_rdata  input  32  instruction word returned by the instruction memory in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump redirect request from a later stage.
REQ-009 redirect_addr  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-010 out_valid  output  1  buffer head holds a valid instruction.
REQ-011 out_ready  input  1  downstream decoder accepts the head this cycle.
REQ-012 out_instr  output  32  instruction at the buffer head.
REQ-013 out_pc  output  32  PC of out_instr.

Function
REQ-014 The FSM SHALL have the states RUN and HALT; HALT exists only when FETCH_HALT_EN is defined.
REQ-015 Pop: when out_valid=1 and out_ready=1, the head entry SHALL be removed at the clock edge.
REQ-016 Push: in RUN with no redirect, when count<DEPTH or a pop occurs in the same cycle, {PC, Instr_rdata} SHALL be written at the tail and the PC SHALL advance by 4.
REQ-017 When the buffer is full and no pop occurs, the PC SHALL hold and nothing SHALL be pushed.
REQ-018 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no error indication.
REQ-019 Latency: an instruction pushed in cycle N SHALL appear as out_valid/out_instr no earlier than cycle N+1, because outputs are registered buffer contents.
REQ-020 When redirect_valid=1, at the edge the buffer SHALL flush (count=0), the PC SHALL load {redirect_addr[31:2],2'b00}, and the state SHALL become RUN; no push SHALL occur that cycle.
REQ-021 Redirect SHALL take priority over a simultaneous pop or push; the popped instruction counts as consumed, and out_valid SHALL be 0 in the following cycle.
REQ-022 Pointers SHALL wrap modulo DEPTH, and FIFO order SHALL be preserved across wrap.
REQ-023 When out_valid=0, out_instr and out_pc SHALL hold their last values; downstream ignores them.
REQ-024 out_valid SHALL be 1 exactly when count>0.

Reset
REQ-025 While reset=1 at a clock edge, the following SHALL be set: PC=RESET_PC, count=0, both pointers=0, state=RUN, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=RESET_PC.
REQ-026 Reset SHALL override redirect_valid and any in-flight push or pop, and SHALL discard buffered entries.
REQ-027 The first fetch from RESET_PC SHALL occur in the first cycle with reset=0.

Configuration
REQ-028 Macro FETCH_HALT_EN: when defined, a pushed Instr_rdata equal to 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) SHALL be pushed normally, after which the state SHALL go to HALT.
REQ-029 In HALT, the PC SHALL hold and nothing SHALL be pushed; buffered entries SHALL still drain; only redirect_valid or reset SHALL return the block to RUN.
REQ-030 When FETCH_HALT_EN is undefined, ECALL and EBREAK SHALL be fetched like any other word and the state SHALL remain RUN.

Verification
REQ-031 Reset release, out_ready=1, memory words 32'h003100B3, 32'h40628233, ... -> out_valid rises one cycle after reset drops with out_pc=0, out_instr=32'h003100B3; next cycle out_pc=4, out_instr=32'h40628233; one instruction per cycle.
REQ-032 out_ready=0 for 6 cycles with DEPTH=2 -> count saturates at 2, Instr_Addr holds at 8, heads stay pc 0 then 4 in order once out_ready=1.
REQ-033 redirect_valid=1 with redirect_addr=32'h0000_0023 while the buffer holds 2 entries and out_ready=1 -> next cycle out_valid=0 and Instr_Addr=32'h0000_0020; the cycle after, out_pc=32'h20.
REQ-034 Redirect to 32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-035 reset asserted for one cycle mid-stream with a full buffer -> following cycle out_valid=0 and Instr_Addr=RESET_PC; no stale entry is ever emitted.
REQ-036 FETCH_HALT_EN defined, word 32'h0000_0073 at address 8 -> pcs 0, 4, 8 are emitted, Instr_Addr holds at 12 indefinitely, and redirect to 0 resumes fetching; with the macro undefined, pc 12 follows pc 8.
